// File: rtl/ps2_cmd_scheduler.sv
// ps2_cmd_scheduler: round-robin arbiter that sends PS/2 host commands with inhibit, retry-on-resend and ACK timeout
module ps2_cmd_scheduler #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int ACK_TIMEOUT    = 1000000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_cmd0,
  input  logic [7:0] req_cmd1,
  output logic [1:0] req_ready,
  output logic       done,
  output logic       done_id,
  output logic [1:0] done_status,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       read_enable
);
  localparam int IW = INHIBIT_CYCLES > 0 ? $clog2(INHIBIT_CYCLES + 1) : 1;
  localparam int TW = ACK_TIMEOUT > 0 ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int RW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [IW-1:0] ILIM = IW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] TLIM = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] TEND = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RLIM = RW'(MAX_RETRIES);
  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, WAIT_TX, WAIT_ACK, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] retries;
  logic last, gnt, ack, nak, tmo;
  // a tie goes to whichever requester was not served last
  assign gnt = &req_valid ? ~last : req_valid[1];
  assign ack = rx_valid && rx_byte == 8'hFA;
  assign nak = rx_valid && rx_byte == 8'hFE;
  assign tmo = tcnt >= TEND;
  // next state and bus-ownership outputs; a received byte beats a simultaneous timeout
  always_comb begin
    state_n = state;
    req_ready = 2'b00;
    tx_start = 1'b0;
    read_enable = 1'b1;
    done = 1'b0;
    case (state)
      IDLE: begin
        req_ready = |req_valid ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        state_n = |req_valid ? INHIBIT : IDLE;
      end
      INHIBIT: begin
        read_enable = 1'b0;
        state_n = icnt == ILIM ? SEND : INHIBIT;
      end
      SEND: begin
        tx_start = 1'b1;
        read_enable = 1'b0;
        state_n = WAIT_TX;
      end
      WAIT_TX: begin
        read_enable = 1'b0;
        state_n = tx_done ? WAIT_ACK : WAIT_TX;
      end
      WAIT_ACK: state_n = ack ? DONE : nak ? (retries >= RLIM ? DONE : INHIBIT) : tmo ? DONE : WAIT_ACK;
      DONE: begin
        done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register, command latch and saturating counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx_byte <= 8'h00;
      icnt <= '0;
      tcnt <= '0;
      retries <= '0;
      last <= 1'b1;
      done_id <= 1'b0;
      done_status <= 2'b00;
    end else begin
      state <= state_n;
      icnt <= state == INHIBIT ? (icnt == ILIM ? icnt : icnt + 1'b1) : '0;
      tcnt <= state == WAIT_ACK ? (tcnt == TLIM ? tcnt : tcnt + 1'b1) : '0;
      if (state == IDLE && |req_valid) begin
        tx_byte <= gnt ? req_cmd1 : req_cmd0;
        last <= gnt;
        retries <= '0;
      end
      if (state == WAIT_ACK && state_n == INHIBIT) retries <= retries + 1'b1;
      if (state == WAIT_ACK && state_n == DONE) begin
        done_id <= last;
        done_status <= ack ? 2'b00 : nak ? 2'b01 : 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// tb_ps2_cmd_scheduler: randomized transaction-level check of the PS/2 command scheduler
module tb_ps2_cmd_scheduler;
  localparam int N = 10, TO = 50, MR = 2;
  logic clk = 0, reset = 1;
  logic [1:0] req_valid = 0, req_ready, done_status;
  logic [7:0] req_cmd0 = 0, req_cmd1 = 0, tx_byte, rx_byte = 0;
  logic done, done_id, tx_start, tx_done = 0, rx_valid = 0, read_enable;
  int errors = 0, checks = 0, last_g = 1;

  ps2_cmd_scheduler #(.INHIBIT_CYCLES(N), .ACK_TIMEOUT(TO), .MAX_RETRIES(MR)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
    .req_ready(req_ready), .done(done), .done_id(done_id), .done_status(done_status),
    .tx_start(tx_start), .tx_byte(tx_byte), .tx_done(tx_done), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .read_enable(read_enable));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode: -1 random response per attempt, 0 ACK, 1 resend every time, 2 silence, 3 ACK in last allowed cycle
  task automatic run_cmd(input logic [1:0] rv, input logic [7:0] c0, input logic [7:0] c1, input int mode);
    int g, attempt, lat, k, kind, d, jd, stat;
    logic [7:0] eb;
    logic bad, noacc;
    g = (rv == 2'b11) ? 1 - last_g : (rv == 2'b10 ? 1 : 0);
    eb = g ? c1 : c0;
    attempt = 0;
    stat = -1;
    lat = N + 2;
    req_valid = rv;
    req_cmd0 = c0;
    req_cmd1 = c1;
    #1;
    check("req_ready", {30'd0, req_ready}, g ? 2 : 1);
    last_g = g;
    while (stat < 0) begin
      k = 0;
      bad = 0;
      noacc = 0;
      do begin
        tick();
        rx_valid = 0;
        k++;
        if (attempt == 0) req_valid = 2'($urandom);
        if (read_enable || done) bad = 1;
        if (req_ready != 0) noacc = 1;
      end while (!tx_start && k < 200);
      req_valid = 0;
      check("start_lat", k, lat);
      check("tx_byte", {24'd0, tx_byte}, {24'd0, eb});
      check("inhibit_bus", {31'd0, bad}, 0);
      check("no_accept", {31'd0, noacc}, 0);
      bad = 0;
      for (int j = $urandom_range(1, 4); j > 0; j--) begin
        tick();
        if (tx_start || read_enable || tx_byte !== eb) bad = 1;
      end
      tx_done = 1;
      #1;
      if (read_enable) bad = 1;
      tick();
      tx_done = 0;
      check("wait_tx", {31'd0, bad}, 0);
      check("rd_en_ack", {31'd0, read_enable}, 1);
      kind = mode < 0 ? int'($urandom_range(0, 2)) : (mode == 3 ? 0 : mode);
      d = kind == 2 ? TO : (mode == 3 ? TO - 1 : int'($urandom_range(0, TO - 1)));
      jd = $urandom_range(0, TO);
      bad = 0;
      for (int c = 0; c < d; c++) begin
        if (c == jd) begin
          rx_valid = 1;
          rx_byte = 8'hAA;
        end
        #1;
        if (done || tx_start) bad = 1;
        tick();
        rx_valid = 0;
      end
      check("ack_wait", {31'd0, bad}, 0);
      if (kind == 2) stat = 2;
      else begin
        rx_valid = 1;
        rx_byte = kind == 0 ? 8'hFA : 8'hFE;
        if (kind == 0) stat = 0;
        else if (attempt == MR) stat = 1;
        else begin
          attempt++;
          lat = N + 2;
        end
        if (stat >= 0) begin
          tick();
          rx_valid = 0;
        end
      end
    end
    check("done", {31'd0, done}, 1);
    check("done_id", {31'd0, done_id}, g);
    check("done_status", {30'd0, done_status}, stat);
    tick();
    check("done_pulse", {31'd0, done}, 0);
    check("status_hold", {29'd0, done_id, done_status}, (g << 2) | stat);
  endtask

  initial begin
    logic bad;
    int k;
    tick();
    tick();
    check("rst_ready", {30'd0, req_ready}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_start", {31'd0, tx_start}, 0);
    check("rst_byte", {24'd0, tx_byte}, 0);
    check("rst_rden", {31'd0, read_enable}, 1);
    check("rst_status", {29'd0, done_id, done_status}, 0);
    reset = 0;
    tick();
    run_cmd(2'b11, 8'hED, 8'hF4, 0);
    run_cmd(2'b11, 8'hED, 8'hF4, 0);
    run_cmd(2'b01, 8'hED, 8'h00, 0);
    run_cmd(2'b10, 8'h11, 8'hF3, 1);
    run_cmd(2'b01, 8'hF2, 8'h22, 2);
    run_cmd(2'b11, 8'h3C, 8'h4D, 3);
    for (int i = 0; i < 20; i++) run_cmd(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), -1);
    req_valid = 2'b01;
    req_cmd0 = 8'h55;
    k = 0;
    do begin
      tick();
      req_valid = 0;
      k++;
    end while (!tx_start && k < 200);
    check("rst_run_start", k, N + 2);
    tick();
    reset = 1;
    tick();
    reset = 0;
    last_g = 1;
    check("abort_rden", {31'd0, read_enable}, 1);
    check("abort_start", {31'd0, tx_start}, 0);
    check("abort_status", {29'd0, done_id, done_status}, 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || tx_start) bad = 1;
    end
    check("abort_quiet", {31'd0, bad}, 0);
    run_cmd(2'b11, 8'hAB, 8'hCD, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_cmd_scheduler.md
PS2_CMD_SCHEDULER -- requirements
Module: ps2_cmd_scheduler

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000: clk cycles read_enable is held low before each transmit.
REQ-002 Parameter ACK_TIMEOUT, default 1000000: clk cycles allowed in WAIT_ACK before timeout.
REQ-003 Parameter MAX_RETRIES, default 2: resends allowed after a 0xFE response.
REQ-004 Port clk  input  1  system clock; the block SHALL use this one clock only.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port req_valid  input  2  per-requester command request (bit0 = requester 0).
REQ-007 Port req_cmd0, req_cmd1  input  8 each  command byte per requester.
REQ-008 Port req_ready  output  2  one-hot, one-cycle acceptance pulse to the granted requester.
REQ-009 Port done  output  1  one-cycle completion pulse.
REQ-010 Port done_id  output  1  requester index of the completed command.
REQ-011 Port done_status  output  2  00 ACK, 01 retries exhausted, 10 timeout.
REQ-012 Port tx_start  output  1  one-cycle start pulse to the PS/2 command transmitter.
REQ-013 Port tx_byte  output  8  byte to transmit; stable from tx_start until tx_done.
REQ-014 Port tx_done  input  1  transmitter completion pulse.
REQ-015 Port rx_valid  input  1  receiver byte-valid pulse.
REQ-016 Port rx_byte  input  8  received byte.
REQ-017 Port read_enable  output  1  receiver enable; low while the host owns the bus.

Function
REQ-018 States SHALL be IDLE, INHIBIT, SEND, WAIT_TX, WAIT_ACK, DONE.
REQ-019 IDLE: on any req_valid, grant round-robin (single requester wins; if both, the one not granted last wins), latch its byte into tx_byte, pulse req_ready for it, clear retry count, go INHIBIT.
REQ-020 INHIBIT: read_enable=0; counter runs INHIBIT_CYCLES cycles, then go SEND.
REQ-021 SEND: tx_start=1 for exactly one cycle, read_enable=0, go WAIT_TX.
REQ-022 WAIT_TX: read_enable=0 until tx_done; then clear timeout counter and go WAIT_ACK.
REQ-023 WAIT_ACK: read_enable=1; rx_valid with 0xFA -> status 00, go DONE.
REQ-024 WAIT_ACK: rx_valid with 0xFE and retries < MAX_RETRIES -> increment retries, go INHIBIT with same tx_byte.
REQ-025 WAIT_ACK: rx_valid with 0xFE and retries == MAX_RETRIES -> status 01, go DONE.
REQ-026 WAIT_ACK: other rx bytes SHALL be ignored and SHALL NOT reset the timeout counter.
REQ-027 WAIT_ACK: timeout counter reaching ACK_TIMEOUT with no terminating byte -> status 10, go DONE; rx_valid arriving in the same cycle takes priority over timeout.
REQ-028 DONE: done=1 for one cycle with done_id/done_status valid, go IDLE; done_id/done_status hold until next DONE.
REQ-029 Requests SHALL NOT be accepted outside IDLE; req_valid deassert mid-command SHALL NOT abort it.
REQ-030 Counters SHALL be sized ceil(log2(param+1)) and SHALL NOT wrap.
REQ-031 Latency from req_valid (IDLE) to tx_start SHALL be INHIBIT_CYCLES+2 cycles.

Reset
REQ-032 Reset SHALL force IDLE, tx_start=0, tx_byte=0x00, read_enable=1, req_ready=0, done=0, done_id=0, done_status=00, counters=0, last-grant=requester 1 (requester 0 wins first tie).
REQ-033 Reset asserted mid-command SHALL abort it next cycle with no done pulse and no further tx_start.

Verification
REQ-034 req_valid=01, cmd0=0xED, rx 0xFA after tx_done -> req_ready=01, tx_byte=0xED, one tx_start, done=1, done_id=0, status 00.
REQ-035 req_valid=11 from reset, both ACK -> first grant requester 0 (0xED), second requester 1 (0xF4), two done pulses, ids 0 then 1.
REQ-036 MAX_RETRIES=2, rx 0xFE three times -> three tx_start pulses with identical tx_byte, done status 01.
REQ-037 ACK_TIMEOUT=50, no rx after tx_done -> done exactly 50 cycles after WAIT_ACK entry, status 10; rx 0xAA mid-wait ignored.
REQ-038 INHIBIT_CYCLES=10: read_enable low from INHIBIT entry through tx_done, tx_start 12 cycles after request.
REQ-039 reset asserted in WAIT_TX -> next cycle read_enable=1, tx_start=0, no done; new request then served normally.
